// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching CPU: opcode values and sequencer state encoding.
package cpu_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_JMP  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction for the 8-bit instruction word held in IR.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [7:0] ir,
   output logic [1:0] op,
   output logic [1:0] rs,
   output logic [1:0] rt,
   output logic [1:0] rd,
   output logic [7:0] imm,
   output logic       alu_sel_imm,
   output logic [5:0] target
);

   // ADDI keeps its destination in IR[3:2]; every other format puts it in IR[1:0].
   always_comb begin
      op          = ir[7:6];
      rs          = ir[5:4];
      rt          = ir[3:2];
      rd          = ir[1:0];
      imm         = {6'b0, ir[1:0]};
      alu_sel_imm = 1'b0;
      target      = ir[5:0];
      if (ir[7:6] == OP_ADDI) begin
         rd          = ir[3:2];
         alu_sel_imm = 1'b1;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: fetches from the program ROM into IR, sequences
// FETCH/DECODE/EXEC/WB and drives register-file/ALU controls from IR.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int PROG_DEPTH = 32,
   parameter int CNT_W      = 16
)(
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic              step_mode,
   input  logic [7:0]        instruction,
   output logic [ADDR_W-1:0] instr_addr,
   output logic [1:0]        rf_rs,
   output logic [1:0]        rf_rt,
   output logic [1:0]        rf_rd,
   output logic              alu_sel_imm,
   output logic [7:0]        imm,
   output logic              rf_we,
   output logic              busy,
   output logic              halted,
   output logic              fault,
   output logic [CNT_W-1:0]  instr_count
);

   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(PROG_DEPTH);

   state_t            state;
   logic [7:0]        ir;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        op;
   logic [5:0]        target;
   logic [ADDR_W:0]   pc_inc;
   logic [ADDR_W:0]   jump_ext;

   // Decoded fields come straight from IR, which only changes in FETCH, so they
   // are stable from DECODE through WB and frozen in HALT.
   instr_decoder u_decoder (
      .ir          (ir),
      .op          (op),
      .rs          (rf_rs),
      .rt          (rf_rt),
      .rd          (rf_rd),
      .imm         (imm),
      .alu_sel_imm (alu_sel_imm),
      .target      (target)
   );

   assign instr_addr = pc;
   assign pc_inc     = {1'b0, pc} + (ADDR_W+1)'(1);
   assign jump_ext   = (ADDR_W+1)'(target);

   // One extra PC bit lets both overrun checks compare against the program depth directly.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state       <= ST_IDLE;
         ir          <= 8'h00;
         pc          <= '0;
         rf_we       <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         instr_count <= '0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               ir    <= instruction;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (op == OP_HALT) begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (op == OP_JMP) begin
                  if (jump_ext >= DEPTH_LIM) begin
                     state  <= ST_HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                     fault  <= 1'b1;
                  end else begin
                     pc <= ADDR_W'(target);
                     if (!(&instr_count))
                        instr_count <= instr_count + CNT_W'(1);
                     if (step_mode) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state <= ST_FETCH;
                     end
                  end
               end else begin
                  state <= ST_WB;
                  rf_we <= 1'b1;
               end
            end
            ST_WB: begin
               if (!(&instr_count))
                  instr_count <= instr_count + CNT_W'(1);
               if (pc_inc == DEPTH_LIM) begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  fault  <= 1'b1;
               end else begin
                  pc <= pc_inc[ADDR_W-1:0];
                  if (step_mode) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboarded bench: an ISA-level reference run queues the expected register
// writes, and a small register-file/ALU model consumes each rf_we pulse.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   localparam int PROG_DEPTH = 32;

   typedef struct {
      logic [1:0] rd;
      logic [7:0] val;
   } wr_t;

   logic        clk;
   logic        clear;
   logic        start;
   logic        step_mode;
   logic [7:0]  instruction;
   logic [7:0]  instr_addr;
   logic [1:0]  rf_rs;
   logic [1:0]  rf_rt;
   logic [1:0]  rf_rd;
   logic        alu_sel_imm;
   logic [7:0]  imm;
   logic        rf_we;
   logic        busy;
   logic        halted;
   logic        fault;
   logic [15:0] instr_count;

   logic [7:0]  mem [0:255];
   logic [7:0]  dp_regs [4];
   logic [7:0]  ref_regs [4];
   wr_t         sb [$];
   int          total;
   int          bad;
   int          pulses;
   int          exp_count;
   int          exp_fault;
   int          exp_pc;
   int          cyc;

   cpu_sequencer #(.ADDR_W(8), .PROG_DEPTH(PROG_DEPTH), .CNT_W(16)) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .step_mode   (step_mode),
      .instruction (instruction),
      .instr_addr  (instr_addr),
      .rf_rs       (rf_rs),
      .rf_rt       (rf_rt),
      .rf_rd       (rf_rd),
      .alu_sel_imm (alu_sel_imm),
      .imm         (imm),
      .rf_we       (rf_we),
      .busy        (busy),
      .halted      (halted),
      .fault       (fault),
      .instr_count (instr_count)
   );

   assign instruction = mem[instr_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Register-file/ALU stand-in: each write strobe is checked against the queued expectation.
   always @(negedge clk) begin
      if (clear && rf_we) begin
         logic [7:0] wdata;
         wr_t        e;
         wdata = dp_regs[rf_rs] + (alu_sel_imm ? imm : dp_regs[rf_rt]);
         pulses++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_we", 32'(rf_we), 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("wb_rd", 32'(rf_rd), 32'(e.rd));
            checkOutput("wb_data", 32'(wdata), 32'(e.val));
         end
         dp_regs[rf_rd] = wdata;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Plain ISA interpreter over mem; queues every architectural register write.
   task automatic refRun();
      int         p;
      logic [7:0] w;
      logic [7:0] v;
      logic [1:0] rd;
      p = 0;
      exp_count = 0;
      exp_fault = 0;
      for (int r = 0; r < 4; r++) ref_regs[r] = 8'h00;
      for (int s = 0; s < 1000; s++) begin
         w = mem[p];
         if (w[7:6] == OP_HALT) break;
         if (w[7:6] == OP_JMP) begin
            if (int'(w[5:0]) >= PROG_DEPTH) begin
               exp_fault = 1;
               break;
            end
            p = int'(w[5:0]);
            exp_count++;
         end else begin
            if (w[7:6] == OP_ADD) begin
               v  = ref_regs[w[5:4]] + ref_regs[w[3:2]];
               rd = w[1:0];
            end else begin
               v  = ref_regs[w[5:4]] + {6'b0, w[1:0]};
               rd = w[3:2];
            end
            ref_regs[rd] = v;
            sb.push_back('{rd, v});
            exp_count++;
            if (p + 1 == PROG_DEPTH) begin
               exp_fault = 1;
               break;
            end
            p++;
         end
      end
      exp_pc = p;
   endtask

   task automatic doReset();
      clear = 1'b0;
      start = 1'b0;
      sb.delete();
      pulses = 0;
      for (int r = 0; r < 4; r++) dp_regs[r] = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear = 1'b1;
   endtask

   task automatic fillHalt();
      for (int a = 0; a < 256; a++) mem[a] = 8'hC3;
   endtask

   task automatic loadFib();
      fillHalt();
      mem[0] = 8'h49;
      mem[1] = 8'h4D;
      mem[2] = 8'h2D;
      mem[3] = 8'h34;
      mem[4] = 8'h13;
      mem[5] = 8'h0E;
      mem[6] = 8'h39;
      mem[7] = 8'h24;
      mem[8] = 8'hC3;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitHalt(input int max_cycles, output int cycles);
      cycles = -1;
      for (int i = 1; i <= max_cycles; i++) begin
         @(posedge clk);
         #1;
         if (halted) begin
            cycles = i;
            break;
         end
      end
      checkOutput("halt_wait", 32'(halted), 32'd1);
   endtask

   task automatic waitIdle(input int max_cycles);
      for (int i = 1; i <= max_cycles; i++) begin
         @(posedge clk);
         #1;
         if (!busy) break;
      end
      checkOutput("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic checkResults();
      checkOutput("halted", 32'(halted), 32'd1);
      checkOutput("busy_end", 32'(busy), 32'd0);
      checkOutput("fault", 32'(fault), 32'(exp_fault));
      checkOutput("count", 32'(instr_count), 32'(exp_count));
      checkOutput("pc_end", 32'(instr_addr), 32'(exp_pc));
      checkOutput("sb_left", 32'(sb.size()), 32'd0);
      for (int r = 0; r < 4; r++) checkOutput("reg", 32'(dp_regs[r]), 32'(ref_regs[r]));
   endtask

   initial begin
      total = 0;
      bad = 0;
      clear = 1'b0;
      start = 1'b0;
      step_mode = 1'b0;
      fillHalt();

      // Asynchronous clear in the middle of an instruction.
      loadFib();
      doReset();
      checkOutput("rst_pc", 32'(instr_addr), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      refRun();
      applyStimulus();
      repeat (22) @(posedge clk);
      #1;
      checkOutput("mid_pc", 32'(instr_addr), 32'd5);
      checkOutput("mid_count", 32'(instr_count), 32'd5);
      checkOutput("mid_busy", 32'(busy), 32'd1);
      #2 clear = 1'b0;
      #1;
      checkOutput("clr_pc", 32'(instr_addr), 32'd0);
      checkOutput("clr_count", 32'(instr_count), 32'd0);
      checkOutput("clr_busy", 32'(busy), 32'd0);
      checkOutput("clr_we", 32'(rf_we), 32'd0);
      checkOutput("clr_halted", 32'(halted), 32'd0);
      checkOutput("clr_rd", 32'(rf_rd), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("clr_hold_pc", 32'(instr_addr), 32'd0);

      // Fibonacci, free-running.
      doReset();
      loadFib();
      step_mode = 1'b0;
      refRun();
      applyStimulus();
      waitHalt(200, cyc);
      checkOutput("fib_latency", 32'(cyc), 32'd34);
      checkOutput("fib_pulses", 32'(pulses), 32'd8);
      checkResults();
      checkOutput("fib_r0", 32'(dp_regs[0]), 32'd21);
      checkOutput("fib_r1", 32'(dp_regs[1]), 32'd13);
      checkOutput("fib_r2", 32'(dp_regs[2]), 32'd8);
      checkOutput("fib_r3", 32'(dp_regs[3]), 32'd5);

      // Fibonacci, single-step.
      doReset();
      loadFib();
      step_mode = 1'b1;
      refRun();
      applyStimulus();
      waitIdle(20);
      checkOutput("step_pulses", 32'(pulses), 32'd1);
      checkOutput("step_pc", 32'(instr_addr), 32'd1);
      checkOutput("step_count", 32'(instr_count), 32'd1);
      checkOutput("step_halted", 32'(halted), 32'd0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         waitIdle(20);
      end
      checkResults();
      step_mode = 1'b0;

      // JMP 3 then HALT, with start held high throughout.
      doReset();
      fillHalt();
      mem[0] = 8'b10000011;
      refRun();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("jmp_pc0", 32'(instr_addr), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("jmp_pc3", 32'(instr_addr), 32'd3);
      waitHalt(20, cyc);
      checkOutput("jmp_halt_lat", 32'(cyc), 32'd2);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("jmp_pulses", 32'(pulses), 32'd0);
      checkResults();
      start = 1'b0;
      clear = 1'b0;
      #1;
      checkOutput("exit_halted", 32'(halted), 32'd0);
      checkOutput("exit_count", 32'(instr_count), 32'd0);

      // Jump target beyond program depth.
      doReset();
      fillHalt();
      mem[0] = 8'b10111111;
      refRun();
      applyStimulus();
      waitHalt(20, cyc);
      checkResults();

      // Write-back from the last program word overruns the PC.
      doReset();
      fillHalt();
      mem[0]  = 8'h9F;
      mem[31] = 8'h47;
      refRun();
      applyStimulus();
      waitHalt(40, cyc);
      checkOutput("overrun_pulses", 32'(pulses), 32'd1);
      checkResults();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
